// File: rtl/pam_pkg.sv
// pam_pkg: shared PAM mapper constants, clog2 helper and width-agnostic Gray-to-binary conversion
package pam_pkg;
  localparam int PAM_BITS_MIN = 2;
  localparam int PAM_BITS_MAX = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [PAM_BITS_MAX-1:0] gray2bin(input logic [PAM_BITS_MAX-1:0] g);
    logic [PAM_BITS_MAX-1:0] b;
    b[PAM_BITS_MAX-1] = g[PAM_BITS_MAX-1];
    for (int k = PAM_BITS_MAX-2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction
endpackage

// File: rtl/sym_fifo.sv
// sym_fifo: show-ahead FIFO (push/din in, pop in, dout head entry, full/empty out), async active-low reset
module sym_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/pam_gray_mapper.sv
// pam_gray_mapper: packs serial bits (data_in/valid/ready) into Gray-coded PAM-N levels on symbol_out/valid/ready, with bypass, flush, bit_cnt and sym_count
module pam_gray_mapper
  import pam_pkg::*;
#(
  parameter int BITS_PER_SYM = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           data_in,
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  input  logic                           bypass,
  input  logic                           flush,
  output logic [BITS_PER_SYM-1:0]        symbol_out,
  output logic                           symbol_out_valid,
  input  logic                           symbol_out_ready,
  output logic [clog2(BITS_PER_SYM)-1:0] bit_cnt,
  output logic [CNT_W-1:0]               sym_count
);
  localparam int CW = clog2(BITS_PER_SYM);
  localparam logic [CW-1:0] LAST = CW'(BITS_PER_SYM-1);
  if (BITS_PER_SYM < PAM_BITS_MIN || BITS_PER_SYM > PAM_BITS_MAX) begin : g_bad_bits
    $error("BITS_PER_SYM out of range");
  end
  logic [BITS_PER_SYM-2:0] packer;
  logic [BITS_PER_SYM-1:0] g, level;
  logic last, accept, done, full, empty;
  assign last = bit_cnt == LAST;
  assign data_in_ready = !(last && full);
  assign accept = data_in_valid && data_in_ready;
  assign done = accept && last && !flush;
  assign g = {packer, data_in};
  assign level = bypass ? g : BITS_PER_SYM'(gray2bin(PAM_BITS_MAX'(g)));
  assign symbol_out_valid = !empty;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      packer <= '0;
      bit_cnt <= '0;
      sym_count <= '0;
    end else begin
      if (flush) begin
        packer <= accept ? (BITS_PER_SYM-1)'(data_in) : '0;
        bit_cnt <= CW'(accept);
      end else if (accept) begin
        packer <= done ? '0 : (BITS_PER_SYM-1)'({packer, data_in});
        bit_cnt <= done ? '0 : bit_cnt + CW'(1);
      end
      sym_count <= sym_count + CNT_W'(done);
    end
  end
  sym_fifo #(.WIDTH(BITS_PER_SYM), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (done),
    .pop   (symbol_out_ready),
    .din   (level),
    .dout  (symbol_out),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_pam_gray_mapper.sv
// tb_pam_gray_mapper: checks PAM4 and PAM8 mappers against a symbol-level model every cycle plus directed literal expectations
module tb_pam_gray_mapper;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rstn = 0;
  always #5 clk = ~clk;
  logic vin [2];
  logic din [2];
  logic byp [2];
  logic fl [2];
  logic srdy [2];
  logic rdy2, rdy3, v2, v3;
  logic [1:0] s2;
  logic [2:0] s3;
  logic [0:0] bc2;
  logic [1:0] bc3;
  logic [3:0] sc2;
  logic [15:0] sc3;
  int checks = 0;
  int failures = 0;
  int mcnt [2];
  int mval [2];
  int wr [2];
  int rd [2];
  int msc [2];
  int exp_q [2][64];
  pam_gray_mapper #(.BITS_PER_SYM(2), .FIFO_DEPTH(DEPTH), .CNT_W(4)) u2 (
    .clk(clk), .rstn(rstn), .data_in(din[0]), .data_in_valid(vin[0]), .data_in_ready(rdy2),
    .bypass(byp[0]), .flush(fl[0]), .symbol_out(s2), .symbol_out_valid(v2),
    .symbol_out_ready(srdy[0]), .bit_cnt(bc2), .sym_count(sc2)
  );
  pam_gray_mapper #(.BITS_PER_SYM(3), .FIFO_DEPTH(DEPTH), .CNT_W(16)) u3 (
    .clk(clk), .rstn(rstn), .data_in(din[1]), .data_in_valid(vin[1]), .data_in_ready(rdy3),
    .bypass(byp[1]), .flush(fl[1]), .symbol_out(s3), .symbol_out_valid(v3),
    .symbol_out_ready(srdy[1]), .bit_cnt(bc3), .sym_count(sc3)
  );
  function automatic int gray_index(input int g, input int b);
    for (int i = 0; i < (1 << b); i++) if ((i ^ (i >> 1)) == g) return i;
    return -1;
  endfunction
  function automatic int act_rdy(input int d); return d != 0 ? int'(rdy3) : int'(rdy2); endfunction
  function automatic int act_v(input int d); return d != 0 ? int'(v3) : int'(v2); endfunction
  function automatic int act_s(input int d); return d != 0 ? int'(s3) : int'(s2); endfunction
  function automatic int act_bc(input int d); return d != 0 ? int'(bc3) : int'(bc2); endfunction
  function automatic int act_sc(input int d); return d != 0 ? int'(sc3) : int'(sc2); endfunction
  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, want, $time);
    end
  endtask
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        mcnt[d] = 0;
        mval[d] = 0;
        wr[d] = 0;
        rd[d] = 0;
        msc[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int b;
        bit ok, acc;
        b = d + 2;
        ok = !(mcnt[d] == b - 1 && wr[d] - rd[d] == DEPTH);
        acc = vin[d] && ok;
        if (wr[d] != rd[d] && srdy[d]) rd[d]++;
        if (fl[d]) begin
          mcnt[d] = acc ? 1 : 0;
          mval[d] = acc ? int'(din[d]) : 0;
        end else if (acc) begin
          mval[d] = mval[d] * 2 + int'(din[d]);
          mcnt[d]++;
          if (mcnt[d] == b) begin
            exp_q[d][wr[d] % 64] = byp[d] ? mval[d] : gray_index(mval[d], b);
            wr[d]++;
            msc[d] = (msc[d] + 1) % (d != 0 ? 65536 : 16);
            mcnt[d] = 0;
            mval[d] = 0;
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rstn) begin
      chk("known", int'($isunknown({rdy2, rdy3, v2, v3, s2, s3, bc2, bc3, sc2, sc3})), 0);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ready%0d", d), act_rdy(d), (mcnt[d] == d + 1 && wr[d] - rd[d] == DEPTH) ? 0 : 1);
        chk($sformatf("valid%0d", d), act_v(d), wr[d] != rd[d] ? 1 : 0);
        if (wr[d] != rd[d]) chk($sformatf("symbol%0d", d), act_s(d), exp_q[d][rd[d] % 64]);
        chk($sformatf("bit_cnt%0d", d), act_bc(d), mcnt[d]);
        chk($sformatf("sym_count%0d", d), act_sc(d), msc[d]);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic push_bit(input int d, input bit b);
    int n;
    n = 0;
    vin[d] = 1;
    din[d] = b;
    while (act_rdy(d) == 0 && n < 50) begin
      tick(1);
      n++;
    end
    if (n == 50) chk("ready_timeout", 0, 1);
    tick(1);
    vin[d] = 0;
  endtask
  task automatic push_bits(input int d, input int v, input int n);
    for (int i = n - 1; i >= 0; i--) push_bit(d, bit'((v >> i) & 1));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    int g4 [4];
    g4 = '{0, 1, 3, 2};
    for (int d = 0; d < 2; d++) begin
      vin[d] = 0;
      din[d] = 0;
      byp[d] = 0;
      fl[d] = 0;
      srdy[d] = 1;
    end
    chk("model_g00", gray_index(0, 2), 0);
    chk("model_g01", gray_index(1, 2), 1);
    chk("model_g11", gray_index(3, 2), 2);
    chk("model_g10", gray_index(2, 2), 3);
    chk("model_g100", gray_index(4, 3), 7);
    chk("model_g110", gray_index(6, 3), 4);
    #3;
    chk("rst_valid", int'(v2), 0);
    chk("rst_symbol", int'(s2), 0);
    chk("rst_bit_cnt", int'(bc2), 0);
    chk("rst_sym_count", int'(sc3), 0);
    @(posedge clk);
    #2;
    rstn = 1;
    #1;
    chk("rst_ready", int'(rdy2), 1);
    tick(1);
    for (int k = 0; k < 4; k++) begin
      push_bits(0, g4[k], 2);
      chk("t1_valid", int'(v2), 1);
      chk("t1_symbol", int'(s2), k);
    end
    chk("t1_sym_count", int'(sc2), 4);
    push_bits(1, 4, 3);
    chk("t2_g100", int'(s3), 7);
    push_bits(1, 6, 3);
    chk("t2_g110", int'(s3), 4);
    byp[1] = 1;
    push_bits(1, 4, 3);
    chk("t2_byp100", int'(s3), 4);
    push_bits(1, 6, 3);
    chk("t2_byp110", int'(s3), 6);
    byp[1] = 0;
    tick(2);
    srdy[0] = 0;
    push_bits(0, 8'b00011110, 8);
    push_bit(0, 1);
    vin[0] = 1;
    din[0] = 1;
    chk("t3_ready_low", int'(rdy2), 0);
    chk("t3_bit_cnt", int'(bc2), 1);
    chk("t3_head", int'(s2), 0);
    tick(3);
    chk("t3_stall_head", int'(s2), 0);
    srdy[0] = 1;
    tick(1);
    srdy[0] = 0;
    chk("t3_pop_head", int'(s2), 1);
    chk("t3_not_taken", int'(bc2), 1);
    chk("t3_ready_back", int'(rdy2), 1);
    tick(1);
    vin[0] = 0;
    chk("t3_taken", int'(bc2), 0);
    chk("t3_sym_count", int'(sc2), 9);
    srdy[0] = 1;
    tick(6);
    chk("t3_drained", int'(v2), 0);
    push_bit(0, 1);
    vin[0] = 1;
    din[0] = 0;
    fl[0] = 1;
    tick(1);
    vin[0] = 0;
    fl[0] = 0;
    chk("t4_flush_bit_cnt", int'(bc2), 1);
    push_bit(0, 1);
    chk("t4_symbol", int'(s2), 1);
    chk("t4_valid", int'(v2), 1);
    push_bit(0, 1);
    fl[0] = 1;
    tick(1);
    fl[0] = 0;
    chk("t4_flush_only", int'(bc2), 0);
    tick(2);
    srdy[0] = 0;
    push_bits(0, 4'b1101, 4);
    push_bit(0, 1);
    chk("t5_pre_head", int'(s2), 2);
    #1;
    rstn = 0;
    #1;
    chk("t5_rst_valid", int'(v2), 0);
    chk("t5_rst_symbol", int'(s2), 0);
    chk("t5_rst_bit_cnt", int'(bc2), 0);
    chk("t5_rst_sym_count", int'(sc2), 0);
    @(posedge clk);
    #2;
    rstn = 1;
    srdy[0] = 1;
    push_bits(0, 2'b10, 2);
    chk("t5_symbol", int'(s2), 3);
    chk("t5_valid", int'(v2), 1);
    chk("t5_sym_count", int'(sc2), 1);
    #1;
    rstn = 0;
    tick(1);
    rstn = 1;
    for (int i = 0; i < 17; i++) push_bits(0, i % 4, 2);
    chk("t6_wrap", int'(sc2), 1);
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
